// File: rtl/pt_serialiser_pkg.sv
// Shared types for the word-to-beat serialiser.
// The beat-count type lives in the module because its width depends on parameters.
package pt_serialiser_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/pt_serialiser.sv
// Word-to-beat serialiser: splits an IN_W word into IN_W/OUT_W beats, LSB slice first.
// Defining PT_SERIALISER_LAST_EN adds the o_rd_last output that marks the final beat.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | no word held, upstream may push
// ST_ACTIVE | word held, beat r_beat presented downstream
module pt_serialiser
    import pt_serialiser_pkg::*;
#(
    parameter  int IN_W      = 32,
    parameter  int OUT_W     = 8,
    localparam int NUM_BEATS = IN_W / OUT_W,
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IN_W-1:0]   i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    output logic [OUT_W-1:0]  o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_busy
`ifdef PT_SERIALISER_LAST_EN
    ,
    output logic              o_rd_last
`endif
);

    typedef logic [BEAT_W-1:0] beat_t;
    localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS - 1);

    if (((IN_W % OUT_W) != 0) || (NUM_BEATS < 2)) begin : g_param_check
        $error("pt_serialiser: IN_W must be a multiple of OUT_W giving at least two beats");
    end

    state_t                         r_state;
    state_t                         w_state_nxt;
    beat_t                          r_beat;
    beat_t                          w_beat_nxt;
    logic [IN_W-1:0]                r_hold;
    logic                           w_load;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_last;
    logic [NUM_BEATS-1:0][OUT_W-1:0] w_slices;

    assign w_last     = (r_beat == LAST_BEAT);
    // Ready on the last beat lets the next word land in the same cycle, so there is no bubble.
    assign o_wr_ready = (r_state == ST_IDLE) || (w_last && i_rd_ready);
    assign o_rd_valid = (r_state == ST_ACTIVE);
    assign o_busy     = (r_state == ST_ACTIVE);
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = o_rd_valid && i_rd_ready;

    assign w_slices   = r_hold;
    assign o_rd_data  = w_slices[r_beat];
    assign o_beat     = r_beat;

`ifdef PT_SERIALISER_LAST_EN
    assign o_rd_last  = o_rd_valid && w_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_ACTIVE;
                    w_beat_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_pop) begin
                    if (!w_last) begin
                        w_beat_nxt = r_beat + beat_t'(1);
                    end else if (w_push) begin
                        w_beat_nxt = '0;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_load) begin
                r_hold <= i_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_pt_serialiser.sv
// Bench for pt_serialiser (IN_W=32, OUT_W=8): directed literal cases plus random traffic
// compared each cycle against a queue-of-pending-beats model.
module tb_pt_serialiser;

    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int NB    = IN_W / OUT_W;
    localparam int BW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IN_W-1:0]  wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [OUT_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [BW-1:0]    beat;
    logic             busy;
`ifdef PT_SERIALISER_LAST_EN
    logic             rd_last;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [OUT_W-1:0] d;
        int               idx;
    } beat_rec_t;

    beat_rec_t q[$];

    always #5 clk = ~clk;

    pt_serialiser #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_data  (wr_data),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_beat     (beat),
        .o_busy     (busy)
`ifdef PT_SERIALISER_LAST_EN
        ,
        .o_rd_last  (rd_last)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the queue holds the beats of the current word still to be delivered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit acc;
            acc = (q.size() == 0) || (q.size() == 1 && rd_ready);
            if (q.size() != 0 && rd_ready) begin
                void'(q.pop_front());
            end
            if (wr_valid && acc) begin
                for (int i = 0; i < NB; i++) begin
                    q.push_back('{d: OUT_W'(wr_data >> (i * OUT_W)), idx: i});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wr_ready", 32'(wr_ready), 32'd1);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data",  32'(rd_data),  32'd0);
            chk("rst_beat",     32'(beat),     32'd0);
            chk("rst_busy",     32'(busy),     32'd0);
`ifdef PT_SERIALISER_LAST_EN
            chk("rst_last",     32'(rd_last),  32'd0);
`endif
        end else begin
            bit exp_valid;
            bit exp_ready;
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() == 0) || (q.size() == 1 && rd_ready);
            chk("m_rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("m_busy",     32'(busy),     32'(exp_valid));
            chk("m_wr_ready", 32'(wr_ready), 32'(exp_ready));
            if (exp_valid) begin
                chk("m_rd_data", 32'(rd_data), 32'(q[0].d));
                chk("m_beat",    32'(beat),    32'(q[0].idx));
            end
`ifdef PT_SERIALISER_LAST_EN
            chk("m_last", 32'(rd_last), 32'(exp_valid && q[0].idx == NB - 1));
`endif
        end
    end

    initial begin
        logic [7:0] w1 [4];
        w1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // single word, downstream always ready
        rd_ready = 1'b1;
        wr_data  = 32'hDDCCBBAA;
        wr_valid = 1'b1;
        #1;
        chk("w1_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("w1_data",  32'(rd_data),  32'(w1[k]));
            chk("w1_beat",  32'(beat),     32'(k));
            chk("w1_valid", 32'(rd_valid), 32'd1);
`ifdef PT_SERIALISER_LAST_EN
            chk("w1_last",  32'(rd_last),  32'(k == 3));
`endif
            tick();
        end
        #1;
        chk("w1_idle_valid", 32'(rd_valid), 32'd0);
        chk("w1_idle_ready", 32'(wr_ready), 32'd1);
`ifdef PT_SERIALISER_LAST_EN
        chk("w1_idle_last",  32'(rd_last),  32'd0);
`endif
        tick();

        // back-to-back words, no gap between them
        wr_data  = 32'h03020100;
        wr_valid = 1'b1;
        tick();
        wr_data = 32'h07060504;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("b2b_data",  32'(rd_data),  32'(k));
            chk("b2b_valid", 32'(rd_valid), 32'd1);
            chk("b2b_beat",  32'(beat),     32'(k % 4));
            tick();
            if (k == 3) wr_valid = 1'b0;
        end
        #1;
        chk("b2b_idle", 32'(rd_valid), 32'd0);
        tick();

        // backpressure at beat 2
        wr_data  = 32'hDDCCBBAA;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        rd_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_data",  32'(rd_data),  32'hCC);
            chk("bp_beat",  32'(beat),     32'd2);
            chk("bp_ready", 32'(wr_ready), 32'd0);
            chk("bp_valid", 32'(rd_valid), 32'd1);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("bp_idle", 32'(rd_valid), 32'd0);
        tick();

        // next word offered while the last beat is popped
        wr_data  = 32'h13121110;
        wr_valid = 1'b1;
        tick();
        wr_data = 32'h23222120;
        tick();
        tick();
        tick();
        #1;
        chk("ov_last_beat",  32'(beat),     32'd3);
        chk("ov_last_data",  32'(rd_data),  32'h13);
        chk("ov_last_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("ov_new_beat",  32'(beat),     32'd0);
        chk("ov_new_data",  32'(rd_data),  32'h20);
        chk("ov_new_valid", 32'(rd_valid), 32'd1);
        repeat (4) tick();

        // reset in the middle of a word
        wr_data  = 32'hDDCCBBAA;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        #1;
        chk("rm_pre_beat", 32'(beat), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(rd_valid), 32'd0);
        chk("rm_ready", 32'(wr_ready), 32'd1);
        chk("rm_data",  32'(rd_data),  32'd0);
        chk("rm_beat",  32'(beat),     32'd0);
        chk("rm_busy",  32'(busy),     32'd0);
`ifdef PT_SERIALISER_LAST_EN
        chk("rm_last",  32'(rd_last),  32'd0);
`endif
        tick();
        tick();
        rst_n    = 1'b1;
        wr_data  = 32'h44332211;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("rm_first_data", 32'(rd_data), 32'h11);
        chk("rm_first_beat", 32'(beat),    32'd0);
        repeat (4) tick();

        // random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom();
            rst_n    = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (6) tick();
        #1;
        chk("end_idle_busy",  32'(busy),     32'd0);
        chk("end_idle_ready", 32'(wr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
